// File: rtl/uart_io_sequencer_if.sv
// Signal bundle between the CPU decode stage, the sequencer and the UART TX/RX cores.
// slave is the sequencer's view; master is the CPU/UART environment's view.
interface uart_io_sequencer_if;
  logic [5:0] opcode;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_timeout;

  modport slave (
    input  opcode, cpu_wdata, tx_busy, rx_data, rx_valid,
    output cpu_rdata, cpu_stall, tx_data, tx_start, rx_overrun, rx_timeout
  );

  modport master (
    output opcode, cpu_wdata, tx_busy, rx_data, rx_valid,
    input  cpu_rdata, cpu_stall, tx_data, tx_start, rx_overrun, rx_timeout
  );
endinterface

// File: rtl/uart_io_sequencer.sv
// Sequences CPU send/receive instructions onto the UART cores, stalling the CPU meanwhile.
// Optional receive timeout is enabled by defining UART_RCV_TIMEOUT_EN.
module uart_io_sequencer #(
  parameter logic [5:0]  OPCODE_SND     = 6'b010001,
  parameter logic [5:0]  OPCODE_RCV     = 6'b010010,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                clock,
  input logic                reset_n,
  uart_io_sequencer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StTxStart = 3'd1;
  localparam logic [2:0] StTxWait  = 3'd2;
  localparam logic [2:0] StRxWait  = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic          busy_seen_q, busy_seen_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic [PtrW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic is_snd, is_rcv;
  logic fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic timeout_hit;

  assign is_snd = (bus.opcode == OPCODE_SND);
  assign is_rcv = (bus.opcode == OPCODE_RCV);

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign fifo_pop   = (state_q == StRxWait) && !fifo_empty;
  assign fifo_push  = bus.rx_valid && (!fifo_full || fifo_pop);

`ifdef UART_RCV_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timeout_cnt_q;
  logic        rx_timeout_q;

  // A byte arriving on the would-be timeout cycle wins and freezes the counter.
  assign timeout_hit = (state_q == StRxWait) && fifo_empty && !bus.rx_valid &&
                       (timeout_cnt_q == TimeoutLast);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_cnt_q <= 16'd0;
      rx_timeout_q  <= 1'b0;
    end else begin
      rx_timeout_q <= timeout_hit;
      if (state_q != StRxWait) begin
        timeout_cnt_q <= 16'd0;
      end else if (fifo_empty && !bus.rx_valid) begin
        timeout_cnt_q <= timeout_cnt_q + 16'd1;
      end
    end
  end

  assign bus.rx_timeout = rx_timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign bus.rx_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    tx_data_d    = tx_data_q;
    cpu_rdata_d  = cpu_rdata_q;
    busy_seen_d  = busy_seen_q;
    rx_overrun_d = rx_overrun_q;

    if (bus.rx_valid && fifo_full && !fifo_pop) begin
      rx_overrun_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (is_snd) begin
          tx_data_d = bus.cpu_wdata;
          state_d   = StTxStart;
        end else if (is_rcv) begin
          state_d = StRxWait;
        end
      end
      StTxStart: begin
        if (!bus.tx_busy) begin
          busy_seen_d = 1'b0;
          state_d     = StTxWait;
        end
      end
      StTxWait: begin
        // Only a falling busy ends the transfer; busy rises one cycle after the start pulse.
        if (bus.tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          state_d = StDone;
        end
      end
      StRxWait: begin
        if (fifo_pop) begin
          cpu_rdata_d = fifo_mem[rd_ptr_q[PtrW-1:0]];
          state_d     = StDone;
        end else if (timeout_hit) begin
          cpu_rdata_d = 8'hFF;
          state_d     = StDone;
        end
      end
      StDone: begin
        // Opcode is ignored here so the instruction just completed is not re-issued.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (state_q)
      StIdle:                       bus.cpu_stall = is_snd || is_rcv;
      StTxStart, StTxWait, StRxWait: bus.cpu_stall = 1'b1;
      default:                      bus.cpu_stall = 1'b0;
    endcase
  end

  assign bus.tx_start   = (state_q == StTxStart) && !bus.tx_busy;
  assign bus.tx_data    = tx_data_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.rx_overrun = rx_overrun_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tx_data_q    <= 8'd0;
      cpu_rdata_q  <= 8'd0;
      busy_seen_q  <= 1'b0;
      rx_overrun_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      tx_data_q    <= tx_data_d;
      cpu_rdata_q  <= cpu_rdata_d;
      busy_seen_q  <= busy_seen_d;
      rx_overrun_q <= rx_overrun_d;
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_q[PtrW-1:0]] <= bus.rx_data;
    end
  end

endmodule
